pstore_array: RTL and testbench

Parametrised successor to the single-layer partial-sum store. It holds one signed accumulator per ReLU node and preloads each accumulator from a stored bias. It adds packed per-node weight contributions under a valid strobe, with optional saturation. After a programmed number of inputs it flags completion, and can apply ReLU on the output. It sits between the weight/multiply stage and the next layer's input register in the NeuralNetwork datapath.

---
 rtl/pstore_array_pkg.sv | 14 +
 rtl/pstore_array_lane.sv | 52 +++++
 rtl/pstore_array.sv | 82 ++++++++
 tb/tb_pstore_array.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pstore_array_pkg.sv
// Shared widths and FSM state encoding for the partial-sum store and the layer sequencer.
package pstore_array_pkg;

  localparam int RELU_NODES            = 2;
  localparam int LAYER_1_BIT_WIDTH     = 8;
  localparam int LAYER_1_OUT_BIT_WIDTH = 10;

  typedef enum logic [1:0] {
    PSTORE_IDLE  = 2'd0,
    PSTORE_ACCUM = 2'd1,
    PSTORE_DONE  = 2'd2
  } pstoreState_t;

endpackage

// File: rtl/pstore_array_lane.sv
// One node lane: bias register, signed accumulator with optional clamp, ReLU output mux.
// Term applied at edge t is visible after edge t; no backpressure, the parent decides what to accept.
module pstore_lane #(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 5,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [IN_WIDTH-1:0]  weightIn,
  input  logic [OUT_WIDTH-1:0] biasIn,
  input  logic                 biasWrite,
  input  logic                 loadNewBias,
  input  logic                 loadOldBias,
  input  logic                 accumulate,
  input  logic                 reluEnable,
  output logic [OUT_WIDTH-1:0] sumOut
);

  localparam logic [OUT_WIDTH-1:0] MAX_VAL = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_VAL = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [OUT_WIDTH-1:0] biasReg;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] accNext;
  logic [OUT_WIDTH:0]   wideSum;

  // One guard bit is enough: the sign-extended term never exceeds the accumulator range.
  always_comb begin
    wideSum = {acc[OUT_WIDTH-1], acc}
            + {{(OUT_WIDTH+1-IN_WIDTH){weightIn[IN_WIDTH-1]}}, weightIn};
    accNext = wideSum[OUT_WIDTH-1:0];
    if (SATURATE != 0 && (wideSum[OUT_WIDTH] != wideSum[OUT_WIDTH-1])) begin
      accNext = wideSum[OUT_WIDTH] ? MIN_VAL : MAX_VAL;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      biasReg <= '0;
      acc     <= '0;
    end else begin
      if (biasWrite) biasReg <= biasIn;
      if (loadNewBias)      acc <= biasIn;
      else if (loadOldBias) acc <= biasReg;
      else if (accumulate)  acc <= accNext;
    end
  end

  assign sumOut = (reluEnable && acc[OUT_WIDTH-1]) ? '0 : acc;

endmodule

// File: rtl/pstore_array.sv
// Per-node partial-sum store: bias preload, NUM_INPUTS accumulations, then DONE until sumClear.
// sumOut updates on the accepting edge; no backpressure, terms arriving in DONE are dropped and flagged.
module pstore_array
  import pstore_array_pkg::*;
#(
  parameter int NODES      = RELU_NODES,
  parameter int IN_WIDTH   = LAYER_1_BIT_WIDTH / RELU_NODES,
  parameter int OUT_WIDTH  = LAYER_1_OUT_BIT_WIDTH / RELU_NODES,
  parameter int NUM_INPUTS = 4,
  parameter int SATURATE   = 1
) (
  input  logic                                clk,
  input  logic                                clr,
  input  logic [NODES*IN_WIDTH-1:0]           weightsIn,
  input  logic                                weightValid,
  input  logic [NODES*OUT_WIDTH-1:0]          biasesIn,
  input  logic                                biasWriteEnable,
  input  logic                                sumClear,
  input  logic                                reluEnable,
  output logic [NODES*OUT_WIDTH-1:0]          sumOut,
  output logic                                sumValid,
  output logic                                busy,
  output logic [$clog2(NUM_INPUTS+1)-1:0]     inCount,
  output logic                                dropErr
);

  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_INPUTS);

  pstoreState_t state;
  logic         loadNewBias;
  logic         loadOldBias;
  logic         accumulate;
  logic [CNT_W-1:0] countNext;

  // Priority is sumClear > biasWriteEnable > weightValid for every lane at once.
  assign loadNewBias = biasWriteEnable && (sumClear || state == PSTORE_IDLE);
  assign loadOldBias = sumClear && !biasWriteEnable;
  assign accumulate  = weightValid && !sumClear && !biasWriteEnable && state != PSTORE_DONE;
  assign countNext   = inCount + 1'b1;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= PSTORE_IDLE;
      inCount <= '0;
      dropErr <= 1'b0;
    end else if (sumClear) begin
      state   <= PSTORE_IDLE;
      inCount <= '0;
      dropErr <= 1'b0;
    end else begin
      if (weightValid && state == PSTORE_DONE) dropErr <= 1'b1;
      if (accumulate) begin
        inCount <= countNext;
        state   <= (countNext == LAST_COUNT) ? PSTORE_DONE : PSTORE_ACCUM;
      end
    end
  end

  assign busy     = (state == PSTORE_ACCUM);
  assign sumValid = (state == PSTORE_DONE);

  for (genvar i = 0; i < NODES; i++) begin : gLane
    pstore_lane #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .SATURATE (SATURATE)
    ) uLane (
      .clk        (clk),
      .clr        (clr),
      .weightIn   (weightsIn[i*IN_WIDTH +: IN_WIDTH]),
      .biasIn     (biasesIn[i*OUT_WIDTH +: OUT_WIDTH]),
      .biasWrite  (biasWriteEnable),
      .loadNewBias(loadNewBias),
      .loadOldBias(loadOldBias),
      .accumulate (accumulate),
      .reluEnable (reluEnable),
      .sumOut     (sumOut[i*OUT_WIDTH +: OUT_WIDTH])
    );
  end

endmodule

// File: tb/tb_pstore_array.sv
// Directed bench: saturating and wrapping builds driven by the same stimulus.
module tb_pstore_array;

  logic       clk;
  logic       clr;
  logic [7:0] weightsIn;
  logic       weightValid;
  logic [9:0] biasesIn;
  logic       biasWriteEnable;
  logic       sumClear;
  logic       reluEnable;

  logic [9:0] sumOutS, sumOutW;
  logic       sumValidS, sumValidW;
  logic       busyS, busyW;
  logic [2:0] inCountS, inCountW;
  logic       dropErrS, dropErrW;

  int nAssert = 0;
  int nFail   = 0;

  pstore_array #(.SATURATE(1)) dutS (
    .clk(clk), .clr(clr), .weightsIn(weightsIn), .weightValid(weightValid),
    .biasesIn(biasesIn), .biasWriteEnable(biasWriteEnable), .sumClear(sumClear),
    .reluEnable(reluEnable), .sumOut(sumOutS), .sumValid(sumValidS), .busy(busyS),
    .inCount(inCountS), .dropErr(dropErrS)
  );

  pstore_array #(.SATURATE(0)) dutW (
    .clk(clk), .clr(clr), .weightsIn(weightsIn), .weightValid(weightValid),
    .biasesIn(biasesIn), .biasWriteEnable(biasWriteEnable), .sumClear(sumClear),
    .reluEnable(reluEnable), .sumOut(sumOutW), .sumValid(sumValidW), .busy(busyW),
    .inCount(inCountW), .dropErr(dropErrW)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseWeight(input logic [7:0] w);
    weightsIn   = w;
    weightValid = 1'b1;
    tick();
    weightValid = 1'b0;
  endtask

  initial begin
    clr = 1'b0; weightsIn = '0; weightValid = 1'b0; biasesIn = '0;
    biasWriteEnable = 1'b0; sumClear = 1'b0; reluEnable = 1'b0;
    #3;
    chk("reset sumOut", 32'(sumOutS), 32'd0);
    chk("reset busy", 32'(busyS), 32'd0);
    chk("reset sumValid", 32'(sumValidS), 32'd0);
    chk("reset inCount", 32'(inCountS), 32'd0);
    chk("reset dropErr", 32'(dropErrS), 32'd0);
    #4 clr = 1'b1;

    // bias preload in IDLE
    biasesIn = 10'b11111_01010; biasWriteEnable = 1'b1;
    tick();
    biasWriteEnable = 1'b0;
    chk("preload sumOut", 32'(sumOutS), 32'(10'b11111_01010));
    chk("preload busy", 32'(busyS), 32'd0);
    chk("preload sumValid", 32'(sumValidS), 32'd0);

    // accumulate and ReLU
    pulseWeight(8'b0101_1010);
    chk("acc1 sumOut", 32'(sumOutS), 32'(10'b00100_00100));
    chk("acc1 inCount", 32'(inCountS), 32'd1);
    chk("acc1 busy", 32'(busyS), 32'd1);
    pulseWeight(8'b1111_1001);
    reluEnable = 1'b1; #1;
    chk("acc2 relu on", 32'(sumOutS), 32'(10'b00011_00000));
    reluEnable = 1'b0; #1;
    chk("acc2 relu off", 32'(sumOutS), 32'(10'b00011_11101));
    chk("acc2 wrap build", 32'(sumOutW), 32'(10'b00011_11101));

    // done and drop
    pulseWeight(8'b0001_0001);
    chk("acc3 inCount", 32'(inCountS), 32'd3);
    chk("acc3 busy", 32'(busyS), 32'd1);
    chk("acc3 sumValid", 32'(sumValidS), 32'd0);
    pulseWeight(8'b0001_0001);
    chk("done sumValid", 32'(sumValidS), 32'd1);
    chk("done inCount", 32'(inCountS), 32'd4);
    chk("done busy", 32'(busyS), 32'd0);
    chk("done sumOut", 32'(sumOutS), 32'(10'b00101_11111));
    chk("done dropErr low", 32'(dropErrS), 32'd0);
    pulseWeight(8'b0001_0001);
    chk("drop sumOut", 32'(sumOutS), 32'(10'b00101_11111));
    chk("drop dropErr", 32'(dropErrS), 32'd1);
    chk("drop inCount", 32'(inCountS), 32'd4);
    sumClear = 1'b1; tick(); sumClear = 1'b0;
    chk("clear sumOut", 32'(sumOutS), 32'(10'b11111_01010));
    chk("clear inCount", 32'(inCountS), 32'd0);
    chk("clear dropErr", 32'(dropErrS), 32'd0);
    chk("clear sumValid", 32'(sumValidS), 32'd0);

    // saturation vs wrap, positive lane0 and negative lane1
    biasesIn = 10'b10000_01111; biasWriteEnable = 1'b1; tick(); biasWriteEnable = 1'b0;
    chk("sat bias load", 32'(sumOutS), 32'(10'b10000_01111));
    pulseWeight(8'b1000_0111);
    chk("sat term1", 32'(sumOutS), 32'(10'b10000_01111));
    chk("wrap term1", 32'(sumOutW), 32'(10'b01000_10110));
    pulseWeight(8'b1000_0111);
    chk("sat term2", 32'(sumOutS), 32'(10'b10000_01111));
    chk("wrap term2", 32'(sumOutW), 32'(10'b00000_11101));
    chk("sat inCount", 32'(inCountS), 32'd2);

    // sumClear beats weightValid
    weightsIn = 8'b0001_0001; weightValid = 1'b1; sumClear = 1'b1;
    tick();
    weightValid = 1'b0; sumClear = 1'b0;
    chk("clr+wv sumOut", 32'(sumOutS), 32'(10'b10000_01111));
    chk("clr+wv wrap sumOut", 32'(sumOutW), 32'(10'b10000_01111));
    chk("clr+wv inCount", 32'(inCountS), 32'd0);
    chk("clr+wv busy", 32'(busyS), 32'd0);

    // bias write mid-ACCUM is deferred to the next sumClear
    biasesIn = 10'b00010_00001; biasWriteEnable = 1'b1; tick(); biasWriteEnable = 1'b0;
    pulseWeight(8'b0001_0001);
    chk("mid acc sumOut", 32'(sumOutS), 32'(10'b00011_00010));
    biasesIn = 10'b00111_00110; biasWriteEnable = 1'b1; tick(); biasWriteEnable = 1'b0;
    chk("mid bwe sumOut held", 32'(sumOutS), 32'(10'b00011_00010));
    chk("mid bwe inCount", 32'(inCountS), 32'd1);
    chk("mid bwe busy", 32'(busyS), 32'd1);
    sumClear = 1'b1; tick(); sumClear = 1'b0;
    chk("deferred bias", 32'(sumOutS), 32'(10'b00111_00110));

    // sumClear together with biasWriteEnable loads the new bias directly
    biasesIn = 10'b01000_00101; biasWriteEnable = 1'b1; sumClear = 1'b1;
    tick();
    biasWriteEnable = 1'b0; sumClear = 1'b0;
    chk("clr+bwe sumOut", 32'(sumOutS), 32'(10'b01000_00101));

    // asynchronous reset mid-ACCUM
    pulseWeight(8'b0001_0001);
    chk("pre-rst sumOut", 32'(sumOutS), 32'(10'b01001_00110));
    chk("pre-rst busy", 32'(busyS), 32'd1);
    #2 clr = 1'b0;
    #1;
    chk("arst sumOut", 32'(sumOutS), 32'd0);
    chk("arst busy", 32'(busyS), 32'd0);
    chk("arst sumValid", 32'(sumValidS), 32'd0);
    chk("arst inCount", 32'(inCountS), 32'd0);
    #1 clr = 1'b1;
    tick(); tick();
    chk("post-rst sumOut", 32'(sumOutS), 32'd0);
    chk("post-rst wrap sumOut", 32'(sumOutW), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
